// File: rtl/branch_target_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: PC, 2-bit counter, BTB entry, FSM states.
// Default table geometry lives here so the interface, top and counter agree on widths.
package branch_target_predictor_pkg;

  localparam int unsigned BTB_ENTRIES = 64;
  localparam int unsigned BTB_INDEX_W = 6;
  localparam int unsigned BTB_GHR_W   = 6;

  typedef logic [31:0] Pc;
  typedef logic [1:0]  Ctr2;

  localparam Ctr2 CTR_WEAK_NT = 2'b01;
  localparam Ctr2 CTR_WEAK_T  = 2'b10;

  // Tag is kept right-aligned in a PC-wide field; the always-zero upper bits fold away in synthesis.
  typedef struct packed {
    logic valid;
    Pc    tag;
    Pc    target;
  } BtbEntry;

  typedef enum logic {INIT, RUN} PredictorState;

  function automatic Pc pc_tag(input Pc pc, input int unsigned index_w);
    return pc >> (index_w + 2);
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Fetch lookup and pipeline resolution bundle between the core and the branch predictor.
// No backpressure: lookups answer combinationally and resolutions are always accepted.
interface branch_target_predictor_if;
  import branch_target_predictor_pkg::*;

  Pc    fetchPc;
  logic predictTaken;
  Pc    predictTarget;
  logic ready;
  logic updateValid;
  logic updateIsBranch;
  Pc    updatePc;
  logic updateTaken;
  Pc    updateTarget;

  modport master (
    output fetchPc, updateValid, updateIsBranch, updatePc, updateTaken, updateTarget,
    input  predictTaken, predictTarget, ready
  );

  modport slave (
    input  fetchPc, updateValid, updateIsBranch, updatePc, updateTaken, updateTarget,
    output predictTaken, predictTarget, ready
  );

endinterface

// File: rtl/branch_target_predictor_sat_counter2.sv
// Next state of a 2-bit saturating direction counter; purely combinational, floors at 00 and ceils at 11.
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  Ctr2  ctr_i,
  input  logic taken_i,
  output Ctr2  ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i && (ctr_i != 2'b11)) begin
      ctr_o = ctr_i + 2'b01;
    end else if (!taken_i && (ctr_i != 2'b00)) begin
      ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor: same-cycle lookup, updates visible next cycle, never stalls.
// Table is cleared by a post-reset sweep; define GSHARE_HISTORY_EN to XOR global history into the counter index.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int unsigned ENTRIES = BTB_ENTRIES,
  parameter int unsigned INDEX_W = BTB_INDEX_W,
  parameter int unsigned GHR_W   = BTB_GHR_W
) (
  input  logic                       clk,
  input  logic                       rst,
  branch_target_predictor_if.slave   bp
);

  typedef logic [INDEX_W-1:0] idx_t;

  PredictorState state_q;
  idx_t          sweep_q;
  logic          ready_q;

  BtbEntry       btb_q [ENTRIES];
  Ctr2           ctr_q [ENTRIES];

  logic [GHR_W-1:0] hist;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          sweep_q <= sweep_q + 1'b1;
          if (sweep_q == idx_t'(ENTRIES - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= INIT;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  idx_t f_idx, f_cidx;
  Pc    f_tag;
  logic f_hit, f_taken;

  always_comb begin
    f_idx   = bp.fetchPc[INDEX_W+1:2];
    f_tag   = pc_tag(bp.fetchPc, INDEX_W);
    f_cidx  = f_idx ^ idx_t'(hist);
    f_hit   = ready_q && btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
    f_taken = f_hit && ctr_q[f_cidx][1];
  end

  assign bp.predictTaken  = f_taken;
  assign bp.predictTarget = f_taken ? btb_q[f_idx].target : bp.fetchPc + 32'd4;
  assign bp.ready         = ready_q;

  idx_t u_idx, u_cidx;
  Pc    u_tag;
  logic u_en, u_hit;
  Ctr2  u_ctr_d;

  always_comb begin
    u_en   = !rst && ready_q && bp.updateValid && bp.updateIsBranch;
    u_idx  = bp.updatePc[INDEX_W+1:2];
    u_tag  = pc_tag(bp.updatePc, INDEX_W);
    u_cidx = u_idx ^ idx_t'(hist);
    u_hit  = btb_q[u_idx].valid && (btb_q[u_idx].tag == u_tag);
  end

  sat_counter2 u_sat (
    .ctr_i   (ctr_q[u_cidx]),
    .taken_i (bp.updateTaken),
    .ctr_o   (u_ctr_d)
  );

  // Table has no reset of its own so it can live in RAM; the sweep clears one entry per cycle.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      btb_q[sweep_q].valid <= 1'b0;
      ctr_q[sweep_q]       <= CTR_WEAK_NT;
    end else if (u_en) begin
      if (u_hit) begin
        ctr_q[u_cidx] <= u_ctr_d;
        if (bp.updateTaken) begin
          btb_q[u_idx].target <= bp.updateTarget;
        end
      end else if (bp.updateTaken) begin
        btb_q[u_idx]  <= '{valid: 1'b1, tag: u_tag, target: bp.updateTarget};
        ctr_q[u_cidx] <= CTR_WEAK_T;
      end
    end
  end

`ifdef GSHARE_HISTORY_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // The update above indexes with the pre-shift history; the shifted value applies from next cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (u_en) begin
      ghr_d = (ghr_q << 1) | GHR_W'(bp.updateTaken);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (state_q == INIT)) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign hist = ghr_q;
`else
  assign hist = '0;
`endif

endmodule
